// File: rtl/tatzel_trim_seq_if.sv
// ---------------------------------------------------------------------------
// tatzel_trim_seq_if -- signal bundle between a controller and the
// tatzel_trim_seq reference-trim sequencer.
//
// Signal semantics (all levels, no valid/ready pairing):
//   start, stop are level-sampled on every rising clk edge; there is no
//   acknowledge. A request is taken when the sequencer is in a state that
//   accepts it and is otherwise silently dropped. stop has priority over start.
//   cmp is asynchronous to clk and is synchronized inside the sequencer.
//
// Ports (slave = sequencer side):
//   start     in   request power-up and trim
//   stop      in   request power-down
//   cmp       in   comparator, 1 = reference above target
//   ref_en    out  reference enable
//   trim      out  TRIM_W trim code to the reference DAC
//   busy      out  trim sequence in progress
//   done      out  trimmed reference running
//   chop      out  chopper clock for the reference amplifier
//   dbg_state out  encoded FSM state for debug/observation
// ---------------------------------------------------------------------------
interface tatzel_trim_seq_if #(
  parameter int TRIM_W = 5
);
  logic              start;
  logic              stop;
  logic              cmp;
  logic              ref_en;
  logic [TRIM_W-1:0] trim;
  logic              busy;
  logic              done;
  logic              chop;
  logic [2:0]        dbg_state;

  modport master (
    output start, stop, cmp,
    input  ref_en, trim, busy, done, chop, dbg_state
  );

  modport slave (
    input  start, stop, cmp,
    output ref_en, trim, busy, done, chop, dbg_state
  );
endinterface

// File: rtl/tatzel_trim_seq.sv
// ---------------------------------------------------------------------------
// tatzel_trim_seq -- power-up and successive-approximation trim sequencer for
// an on-chip voltage reference.
//
// After start the reference is enabled and allowed to settle, then each trim
// bit from MSB to LSB is tried: the bit is set, the reference settles, and
// the synchronized comparator decides whether the bit is kept. When all bits
// are decided the block sits in RUN holding the code. stop powers down at any
// time and leaves the last trim code on the bus.
//
// Parameters:
//   TRIM_W     trim code width (2..8)
//   SETTLE_CYC settle cycles after power-up and after each trial bit (3..255)
//   CHOP_DIV   chopper half-period in clk cycles while in RUN (1..255)
//
// Optional feature macro: TATZEL_TRIM_CHOP_EN
//   defined   -> chop toggles every CHOP_DIV cycles in RUN, 0 elsewhere
//   undefined -> chop tied to 0, no divider, CHOP_DIV unused
//
// Ports:
//   clk  in   clock, all state on rising edge
//   rst  in   asynchronous active-high reset
//   bus  tatzel_trim_seq_if.slave (start, stop, cmp in; ref_en, trim, busy,
//        done, chop, dbg_state out)
// ---------------------------------------------------------------------------
module tatzel_trim_seq #(
  parameter int TRIM_W     = 5,
  parameter int SETTLE_CYC = 64,
  parameter int CHOP_DIV   = 8
) (
  input logic               clk,
  input logic               rst,
  tatzel_trim_seq_if.slave  bus
);

  localparam int            IW          = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
  // Counter is loaded with SETTLE_CYC-1 on state entry and the state exits
  // on the cycle it reads 0, giving exactly SETTLE_CYC cycles in the state.
  localparam logic [7:0]    SETTLE_LOAD = 8'(SETTLE_CYC - 1);
  localparam logic [IW-1:0] TOP_BIT     = IW'(TRIM_W - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_POWERUP = 3'd1,
    S_TRIAL   = 3'd2,
    S_WAIT    = 3'd3,
    S_DECIDE  = 3'd4,
    S_RUN     = 3'd5
  } state_t;

  state_t            state;
  logic [7:0]        settle_cnt;
  logic [IW-1:0]     bit_idx;
  logic [TRIM_W-1:0] trim_q;
  logic              ref_en_q;
  logic              busy_q;
  logic              done_q;
  logic              cmp_meta;
  logic              cmp_s;

`ifdef TATZEL_TRIM_CHOP_EN
  localparam logic [7:0] CHOP_LAST = 8'(CHOP_DIV - 1);
  logic       chop_q;
  logic [7:0] chop_cnt;
`endif

  // Two-flop synchronizer for the asynchronous comparator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_meta <= 1'b0;
      cmp_s    <= 1'b0;
    end else begin
      cmp_meta <= bus.cmp;
      cmp_s    <= cmp_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      bit_idx    <= '0;
      trim_q     <= '0;
      ref_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef TATZEL_TRIM_CHOP_EN
      chop_q     <= 1'b0;
      chop_cnt   <= '0;
`endif
    end else if (state != S_IDLE && bus.stop) begin
      // Power-down from anywhere; the trim code is deliberately kept.
      state      <= S_IDLE;
      settle_cnt <= '0;
      ref_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef TATZEL_TRIM_CHOP_EN
      chop_q     <= 1'b0;
      chop_cnt   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          // stop wins over start even in IDLE.
          if (bus.start && !bus.stop) begin
            state      <= S_POWERUP;
            trim_q     <= '0;
            settle_cnt <= SETTLE_LOAD;
            ref_en_q   <= 1'b1;
            busy_q     <= 1'b1;
          end
        end

        S_POWERUP: begin
          if (settle_cnt == 8'd0) begin
            state   <= S_TRIAL;
            bit_idx <= TOP_BIT;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end

        S_TRIAL: begin
          trim_q[bit_idx] <= 1'b1;
          settle_cnt      <= SETTLE_LOAD;
          state           <= S_WAIT;
        end

        S_WAIT: begin
          if (settle_cnt == 8'd0) begin
            state <= S_DECIDE;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end

        S_DECIDE: begin
          // Reference above target with this bit set: drop the bit.
          if (cmp_s) begin
            trim_q[bit_idx] <= 1'b0;
          end
          if (bit_idx == '0) begin
            state  <= S_RUN;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            bit_idx <= bit_idx - IW'(1);
            state   <= S_TRIAL;
          end
        end

        S_RUN: begin
          if (bus.start) begin
            // Re-trim with the reference already powered: skip POWERUP.
            state   <= S_TRIAL;
            trim_q  <= '0;
            bit_idx <= TOP_BIT;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
`ifdef TATZEL_TRIM_CHOP_EN
            chop_q   <= 1'b0;
            chop_cnt <= '0;
`endif
          end else begin
`ifdef TATZEL_TRIM_CHOP_EN
            if (chop_cnt == CHOP_LAST) begin
              chop_cnt <= '0;
              chop_q   <= ~chop_q;
            end else begin
              chop_cnt <= chop_cnt + 8'd1;
            end
`endif
          end
        end

        default: begin
          state    <= S_IDLE;
          ref_en_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ref_en    = ref_en_q;
  assign bus.trim      = trim_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dbg_state = state;

`ifdef TATZEL_TRIM_CHOP_EN
  assign bus.chop = chop_q;
`else
  assign bus.chop = 1'b0;
`endif

endmodule

// File: tb/tb_tatzel_trim_seq.sv
// ---------------------------------------------------------------------------
// tb_tatzel_trim_seq -- self-checking bench for tatzel_trim_seq with
// TRIM_W=5, SETTLE_CYC=4, CHOP_DIV=3. The comparator is emulated as
// (trim > thr) or forced to a constant; expected trim codes and latencies
// come from a timeline model of the trim sequence.
// ---------------------------------------------------------------------------
module tb_tatzel_trim_seq;

  localparam int W        = 5;
  localparam int S        = 4;
  localparam int CD       = 3;
  localparam int LAT_COLD = S + W * (S + 2) + 1;
  localparam int LAT_WARM = W * (S + 2) + 1;
  localparam int MAXV     = (1 << W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tatzel_trim_seq_if #(.TRIM_W(W)) bus ();

  tatzel_trim_seq #(
    .TRIM_W    (W),
    .SETTLE_CYC(S),
    .CHOP_DIV  (CD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Comparator emulation: reference above target when trim exceeds thr.
  int   thr       = 19;
  logic force_en  = 1'b0;
  logic force_val = 1'b0;
  assign bus.cmp = force_en ? force_val : (int'(bus.trim) > thr);

  // ---------------- scoreboard ----------------
  int             checks   = 0;
  int             failures = 0;
  logic [W-1:0]   exp_q[$];
  bit             in_run   = 1'b0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Final SAR code: the largest code whose comparator reads 0.
  function automatic int model_final(int t, bit fe, bit fv);
    if (fe) return fv ? 0 : MAXV;
    if (t < 0) return 0;
    if (t > MAXV) return MAXV;
    return t;
  endfunction

  // Trim code visible k cycles after a cold start was sampled.
  function automatic int model_trim_at(int k, int t);
    int v;
    v = 0;
    for (int j = 0; j < W; j++) begin
      int b;
      b = 1 << (W - 1 - j);
      if (k >= S + j * (S + 2) + 1) v = v | b;
      if (k >= S + (j + 1) * (S + 2) && v > t) v = v & ~b;
    end
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start_and_measure(input int exp_lat, input string name);
    int           cycles;
    logic [W-1:0] exp_trim;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cycles = 1;
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_busy_after_start got=%b exp=1", name, bus.busy);
    end
    while (bus.done !== 1'b1 && cycles < 400) begin
      checks++;
      if ({bus.ref_en, bus.busy, bus.chop} !== 3'b110) begin
        failures++;
        $display("FAIL %s_trim_phase cycle=%0d got ref_en/busy/chop=%b exp=110",
                 name, cycles, {bus.ref_en, bus.busy, bus.chop});
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    exp_trim = exp_q.pop_front();
    checks++;
    if (cycles != exp_lat) begin
      failures++;
      $display("FAIL %s_latency got=%0d exp=%0d", name, cycles, exp_lat);
    end
    checks++;
    if (bus.trim !== exp_trim) begin
      failures++;
      $display("FAIL %s_trim got=%0d exp=%0d", name, bus.trim, exp_trim);
    end
    checks++;
    if ({bus.ref_en, bus.busy} !== 2'b10) begin
      failures++;
      $display("FAIL %s_run_flags got ref_en/busy=%b exp=10", name, {bus.ref_en, bus.busy});
    end
    in_run = 1'b1;
  endtask

  task automatic go_idle(input string name);
    @(negedge clk);
    bus.stop = 1'b1;
    @(posedge clk);
    #1;
    bus.stop = 1'b0;
    checks++;
    if ({bus.ref_en, bus.busy, bus.done, bus.chop} !== 4'b0000) begin
      failures++;
      $display("FAIL %s_stop got ref_en/busy/done/chop=%b exp=0000", name,
               {bus.ref_en, bus.busy, bus.done, bus.chop});
    end
    in_run = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.ref_en, bus.busy, bus.done, bus.chop} !== 4'b0000 || bus.trim !== '0) begin
      failures++;
      $display("FAIL reset_outputs got ref_en/busy/done/chop=%b trim=%0d exp=0000 trim=0",
               {bus.ref_en, bus.busy, bus.done, bus.chop}, bus.trim);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.ref_en, bus.busy, bus.done} !== 3'b000) begin
      failures++;
      $display("FAIL reset_idle got ref_en/busy/done=%b exp=000", {bus.ref_en, bus.busy, bus.done});
    end
  endtask

  task automatic test_trim_nominal();
    force_en = 1'b0;
    thr      = 19;
    exp_q.push_back(W'(model_final(thr, 1'b0, 1'b0)));
    start_and_measure(LAT_COLD, "nominal");
  endtask

  // Must run directly after a trim completes: interval 0 of RUN.
  task automatic test_chop();
    for (int m = 0; m < 24; m++) begin
      logic exp_chop;
`ifdef TATZEL_TRIM_CHOP_EN
      exp_chop = ((m / CD) % 2) == 1;
`else
      exp_chop = 1'b0;
`endif
      checks++;
      if (bus.chop !== exp_chop) begin
        failures++;
        $display("FAIL chop_run m=%0d got=%b exp=%b", m, bus.chop, exp_chop);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_run_restart();
    force_en = 1'b0;
    thr      = 19;
    exp_q.push_back(W'(model_final(thr, 1'b0, 1'b0)));
    start_and_measure(in_run ? LAT_WARM : LAT_COLD, "run_restart");
  endtask

  task automatic test_cmp_held();
    go_idle("held_pre1");
    force_en  = 1'b1;
    force_val = 1'b1;
    exp_q.push_back(W'(model_final(0, 1'b1, 1'b1)));
    start_and_measure(LAT_COLD, "cmp_high");
    go_idle("held_pre0");
    force_val = 1'b0;
    exp_q.push_back(W'(model_final(0, 1'b1, 1'b0)));
    start_and_measure(LAT_COLD, "cmp_low");
    force_en = 1'b0;
  endtask

  task automatic test_stop_mid_trim();
    logic [W-1:0] exp_frozen;
    go_idle("stopmid_pre");
    thr = 19;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
    end
    exp_frozen = W'(model_trim_at(12, thr));
    bus.stop = 1'b1;
    @(posedge clk);
    #1;
    bus.stop = 1'b0;
    checks++;
    if ({bus.ref_en, bus.busy, bus.done} !== 3'b000) begin
      failures++;
      $display("FAIL stop_mid_flags got ref_en/busy/done=%b exp=000", {bus.ref_en, bus.busy, bus.done});
    end
    checks++;
    if (bus.trim !== exp_frozen) begin
      failures++;
      $display("FAIL stop_mid_trim got=%0d exp=%0d", bus.trim, exp_frozen);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (bus.trim !== exp_frozen || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL stop_mid_hold got trim=%0d busy=%b exp trim=%0d busy=0",
               bus.trim, bus.busy, exp_frozen);
    end
    in_run = 1'b0;
    exp_q.push_back(W'(model_final(thr, 1'b0, 1'b0)));
    start_and_measure(LAT_COLD, "stop_restart");
  endtask

  task automatic test_rst_mid_wait();
    go_idle("rstmid_pre");
    thr = 19;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    // Mid-cycle, away from any edge: reset must act without a clock.
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.ref_en, bus.busy, bus.done, bus.chop} !== 4'b0000 || bus.trim !== '0) begin
      failures++;
      $display("FAIL rst_async got ref_en/busy/done/chop=%b trim=%0d exp=0000 trim=0",
               {bus.ref_en, bus.busy, bus.done, bus.chop}, bus.trim);
    end
    @(negedge clk);
    rst    = 1'b0;
    in_run = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({bus.ref_en, bus.busy, bus.done} !== 3'b000) begin
      failures++;
      $display("FAIL rst_waits_start got ref_en/busy/done=%b exp=000", {bus.ref_en, bus.busy, bus.done});
    end
    @(negedge clk);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    checks++;
    if ({bus.ref_en, bus.busy, bus.done} !== 3'b000) begin
      failures++;
      $display("FAIL start_stop_idle got ref_en/busy/done=%b exp=000", {bus.ref_en, bus.busy, bus.done});
    end
    exp_q.push_back(W'(model_final(thr, 1'b0, 1'b0)));
    start_and_measure(LAT_COLD, "after_rst");
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int t;
      bit warm;
      t    = int'($urandom_range(0, 40));
      warm = in_run && ($urandom_range(0, 1) == 1);
      if (!warm) go_idle("rand_pre");
      force_en = 1'b0;
      thr      = t;
      exp_q.push_back(W'(model_final(t, 1'b0, 1'b0)));
      start_and_measure(warm ? LAT_WARM : LAT_COLD, warm ? "rand_warm" : "rand_cold");
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_trim_nominal();
    test_chop();
    test_run_restart();
    test_cmp_held();
    test_stop_mid_trim();
    test_rst_mid_wait();
    test_random();
    go_idle("final");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
